// File: rtl/dl_lshift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dl_lshift_pkg
// Description : Shared helpers for the dl_lshift logarithmic barrel shifter.
// Revision    : 1.0 - initial release
// ============================================================================
package dl_lshift_pkg;

    // Smallest data width the shifter supports.
    localparam int unsigned DL_LSHIFT_MIN_BITS = 2;

    // Shift distance applied by stage k of the barrel shifter (2^k).
    function automatic int stage_shift(input int k);
        return 1 << k;
    endfunction

endpackage : dl_lshift_pkg
`default_nettype wire

// File: rtl/dl_lshift_stage.sv
`default_nettype none
// ============================================================================
// Module      : dl_lshift_stage
// Description : One mux stage of the barrel shifter: shifts left by a fixed
//               SHIFT when sel is high, otherwise passes data through.
// Revision    : 1.0 - initial release
// ============================================================================
module dl_lshift_stage #(
    parameter int NUM_BITS = 8,
    parameter int SHIFT    = 1
) (
    input  logic [NUM_BITS-1:0] in,
    input  logic                sel,
    output logic [NUM_BITS-1:0] out
);

    // Explicit concatenation keeps X/Z confined to the bits they move into.
    logic [NUM_BITS-1:0] w_shifted;
    assign w_shifted = {in[NUM_BITS-1-SHIFT:0], {SHIFT{1'b0}}};

    // Select between the shifted and the pass-through value.
    assign out = sel ? w_shifted : in;

endmodule : dl_lshift_stage
`default_nettype wire

// File: rtl/dl_lshift.sv
`default_nettype none
// ============================================================================
// Module      : dl_lshift
// Description : Parameterized logical left shifter built as a log2-staged
//               barrel shifter, with an optional registered output.
// Revision    : 1.0 - initial release
// ============================================================================
module dl_lshift
    import dl_lshift_pkg::*;
#(
    parameter int NUM_BITS       = 8,
    parameter int NUM_SHIFT_BITS = $clog2(NUM_BITS),
    parameter int REGISTER_OUT   = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_BITS-1:0]       in,
    input  logic [NUM_SHIFT_BITS-1:0] shamt,
    output logic [NUM_BITS-1:0]       out
);

    // Width limit expressed in the shift-amount domain plus one bit, so the
    // overshift compare never truncates NUM_BITS.
    localparam logic [NUM_SHIFT_BITS:0] c_num_bits = (NUM_SHIFT_BITS + 1)'(NUM_BITS);

    // w_stage[k] is the input of stage k; w_stage[NUM_SHIFT_BITS] the final shift.
    logic [NUM_BITS-1:0] w_stage [0:NUM_SHIFT_BITS];
    logic                w_overshift;
    logic [NUM_BITS-1:0] w_result;

    assign w_stage[0] = in;

    // Chain the stages from the 1-bit shift up to the largest power of two.
    generate
        for (genvar k = 0; k < NUM_SHIFT_BITS; k++) begin : g_stage
            dl_lshift_stage #(
                .NUM_BITS (NUM_BITS),
                .SHIFT    (stage_shift(k))
            ) u_stage (
                .in  (w_stage[k]),
                .sel (shamt[k]),
                .out (w_stage[k+1])
            );
        end
    endgenerate

    // Shift amounts at or beyond the width move every bit out; only reachable
    // when NUM_BITS is not a power of two.
    assign w_overshift = ({1'b0, shamt} >= c_num_bits);
    assign w_result    = w_overshift ? '0 : w_stage[NUM_SHIFT_BITS];

    generate
        if (REGISTER_OUT != 0) begin : g_reg_out
            logic [NUM_BITS-1:0] r_out;

            // Capture the shift result every cycle; reset clears it at once.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_out <= '0;
                end else begin
                    r_out <= w_result;
                end
            end

            assign out = r_out;
        end else begin : g_comb_out
            // Clock and reset have no function in the combinational variant.
            logic w_unused;
            assign w_unused = clk | rst;

            assign out = w_result;
        end
    endgenerate

endmodule : dl_lshift
`default_nettype wire

// File: tb/tb_dl_lshift.sv
`default_nettype none
// ============================================================================
// Module      : tb_dl_lshift
// Description : Self-checking bench for dl_lshift: directed cases plus a
//               randomized scoreboard run over combinational and registered
//               variants at several widths.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dl_lshift;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Device instances: 8/6/32-bit combinational, 8/32-bit registered.
    logic [7:0]  in8c,  out8c;  logic [2:0] sh8c;
    logic [5:0]  in6c,  out6c;  logic [2:0] sh6c;
    logic [31:0] in32c, out32c; logic [4:0] sh32c;
    logic [7:0]  in8r,  out8r;  logic [2:0] sh8r;
    logic [31:0] in32r, out32r; logic [4:0] sh32r;

    dl_lshift #(.NUM_BITS(8),  .REGISTER_OUT(0)) u8c  (.clk(clk), .rst(rst), .in(in8c),  .shamt(sh8c),  .out(out8c));
    dl_lshift #(.NUM_BITS(6),  .REGISTER_OUT(0)) u6c  (.clk(clk), .rst(rst), .in(in6c),  .shamt(sh6c),  .out(out6c));
    dl_lshift #(.NUM_BITS(32), .REGISTER_OUT(0)) u32c (.clk(clk), .rst(rst), .in(in32c), .shamt(sh32c), .out(out32c));
    dl_lshift #(.NUM_BITS(8),  .REGISTER_OUT(1)) u8r  (.clk(clk), .rst(rst), .in(in8r),  .shamt(sh8r),  .out(out8r));
    dl_lshift #(.NUM_BITS(32), .REGISTER_OUT(1)) u32r (.clk(clk), .rst(rst), .in(in32r), .shamt(sh32r), .out(out32r));

    int checks   = 0;
    int failures = 0;
    bit run_rand = 1'b0;

    // Scoreboard queues: expected outputs pushed at stimulus time.
    logic [31:0] q8c[$], q6c[$], q32c[$], q8r[$], q32r[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the n-bit window of an unbounded left shift, zero past the width.
    function automatic logic [31:0] model(input logic [31:0] v, input int unsigned sh, input int unsigned n);
        logic [63:0] wide;
        logic [63:0] mask;
        if (sh >= n) return 32'h0;
        wide = {32'h0, v} << sh;
        mask = (64'd1 << n) - 64'd1;
        return 32'(wide & mask);
    endfunction

    // Monitor: combinational outputs are compared in the same cycle they were
    // driven; registered outputs against the entry issued one cycle earlier.
    always @(negedge clk) begin
        if (run_rand) begin
            if (q8c.size()  > 0) check("rnd8c",  {24'h0, out8c}, q8c.pop_front());
            if (q6c.size()  > 0) check("rnd6c",  {26'h0, out6c}, q6c.pop_front());
            if (q32c.size() > 0) check("rnd32c", out32c,         q32c.pop_front());
            if (q8r.size()  >= 2) check("rnd8r",  {24'h0, out8r}, q8r.pop_front());
            if (q32r.size() >= 2) check("rnd32r", out32r,         q32r.pop_front());
        end
    end

    initial begin
        logic [7:0] walk [0:7];
        walk = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};

        in8c = 8'h0; sh8c = '0; in6c = 6'h0; sh6c = '0; in32c = 32'h0; sh32c = '0;
        in8r = 8'h0; sh8r = '0; in32r = 32'h0; sh32r = '0;

        // ---- Combinational directed cases ----
        in8c = 8'h01; sh8c = 3'd3; #1 check("c8_01_s3", {24'h0, out8c}, 32'h08);
        in8c = 8'hA5; sh8c = 3'd0; #1 check("c8_A5_s0", {24'h0, out8c}, 32'hA5);
        in8c = 8'hFF; sh8c = 3'd7; #1 check("c8_FF_s7", {24'h0, out8c}, 32'h80);
        in8c = 8'hA5; sh8c = 3'd4; #1 check("c8_A5_s4", {24'h0, out8c}, 32'h50);
        for (int i = 0; i < 8; i++) begin
            in8c = 8'hFF; sh8c = 3'(i);
            #1 check($sformatf("walk_s%0d", i), {24'h0, out8c}, {24'h0, walk[i]});
        end
        in6c = 6'h3F; sh6c = 3'd5; #1 check("c6_s5", {26'h0, out6c}, 32'h20);
        in6c = 6'h3F; sh6c = 3'd6; #1 check("c6_s6", {26'h0, out6c}, 32'h00);
        in6c = 6'h3F; sh6c = 3'd7; #1 check("c6_s7", {26'h0, out6c}, 32'h00);

        // ---- Registered directed cases (rst asserted since time 0) ----
        check("r8_rst_init", {24'h0, out8r}, 32'h0);
        check("r32_rst_init", out32r, 32'h0);
        in8r = 8'hFF; sh8r = 3'd0;
        @(posedge clk); #1 check("r8_rst_hold", {24'h0, out8r}, 32'h0);
        @(negedge clk);
        rst = 1'b0; in8r = 8'h03; sh8r = 3'd1;
        #1 check("r8_pre_edge", {24'h0, out8r}, 32'h0);
        @(posedge clk); #1 check("r8_first_cap", {24'h0, out8r}, 32'h06);
        #2 in8r = 8'h0F; sh8r = 3'd2;
        #1 check("r8_mid_change", {24'h0, out8r}, 32'h06);
        @(posedge clk); #1 check("r8_next_edge", {24'h0, out8r}, 32'h3C);
        #2 rst = 1'b1;
        #1 check("r8_async_rst", {24'h0, out8r}, 32'h0);
        @(posedge clk); #1 check("r8_rst_discard", {24'h0, out8r}, 32'h0);
        @(negedge clk); rst = 1'b0;

        // ---- Randomized scoreboard run ----
        run_rand = 1'b1;
        repeat (300) begin
            @(posedge clk);
            #($urandom_range(1, 4));
            in8c  = 8'($urandom);  sh8c  = 3'($urandom);
            in6c  = 6'($urandom);  sh6c  = 3'($urandom);
            in32c = $urandom;      sh32c = 5'($urandom);
            in8r  = 8'($urandom);  sh8r  = 3'($urandom);
            in32r = $urandom;      sh32r = 5'($urandom);
            q8c.push_back(model({24'h0, in8c}, sh8c, 8));
            q6c.push_back(model({26'h0, in6c}, sh6c, 6));
            q32c.push_back(model(in32c, sh32c, 32));
            q8r.push_back(model({24'h0, in8r}, sh8r, 8));
            q32r.push_back(model(in32r, sh32r, 32));
        end
        @(posedge clk);
        @(negedge clk);
        #1 run_rand = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_dl_lshift
`default_nettype wire
